// File: rtl/mips32_trace_buffer_if.sv
// ----------------------------------------------------------------------------
// mips32_trace_buffer_if
//   Capture and readout bundle for the mips32 instruction trace buffer.
//   Capture side : cap_valid, cap_pc, cap_instr, cap_result, cap_ctrl
//                  (one retired instruction per cycle when cap_valid).
//   Readout side : rd_valid/rd_ready stream carrying rd_pc, rd_instr,
//                  rd_result, rd_ctrl (and rd_time when
//                  MIPS32_TRACE_TIMESTAMP_EN is defined).
//   Modports     : master - core/debug consumer side (drives capture, accepts
//                           readout); slave - the trace buffer itself.
// ----------------------------------------------------------------------------
interface mips32_trace_buffer_if #(
    parameter int DATA_W = 32
);
    logic              cap_valid;
    logic [DATA_W-1:0] cap_pc;
    logic [DATA_W-1:0] cap_instr;
    logic [DATA_W-1:0] cap_result;
    logic [4:0]        cap_ctrl;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_instr;
    logic [DATA_W-1:0] rd_result;
    logic [4:0]        rd_ctrl;
`ifdef MIPS32_TRACE_TIMESTAMP_EN
    logic [15:0]       rd_time;

    modport master (
        output cap_valid, cap_pc, cap_instr, cap_result, cap_ctrl, rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_result, rd_ctrl, rd_time
    );
    modport slave (
        input  cap_valid, cap_pc, cap_instr, cap_result, cap_ctrl, rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_result, rd_ctrl, rd_time
    );
`else
    modport master (
        output cap_valid, cap_pc, cap_instr, cap_result, cap_ctrl, rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_result, rd_ctrl
    );
    modport slave (
        input  cap_valid, cap_pc, cap_instr, cap_result, cap_ctrl, rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_result, rd_ctrl
    );
`endif
endinterface

// File: rtl/mips32_trace_buffer.sv
// ----------------------------------------------------------------------------
// mips32_trace_buffer
//   Instruction-trace capture unit. Retired instructions are written into a
//   DEPTH-entry circular buffer while ARMED; a PC match (or force_trig) moves
//   to POST, which records POST_TRIG further entries, then the buffer freezes
//   (DONE) and drains oldest-first over the rd_valid/rd_ready stream.
//
//   Optional feature macro: MIPS32_TRACE_TIMESTAMP_EN
//     Adds a 16-bit free-running cycle counter stored with each entry and
//     presented on bus.rd_time.
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     arm             pulse: IDLE -> ARMED, buffer emptied
//     abort           any state -> IDLE, buffer discarded (highest priority)
//     force_trig      trigger immediately while ARMED
//     trig_pc         PC value that fires the trigger
//     bus (slave)     capture inputs and readout stream
//     state           00 IDLE, 01 ARMED, 10 POST, 11 DONE
//     count           entries held (saturates at DEPTH)
//     triggered       high from the trigger until return to IDLE
// ----------------------------------------------------------------------------
module mips32_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int POST_TRIG = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                abort,
    input  logic                force_trig,
    input  logic [DATA_W-1:0]   trig_pc,
    mips32_trace_buffer_if.slave bus,
    output logic [1:0]          state,
    output logic [ADDR_W:0]     count,
    output logic                triggered
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    typedef struct packed {
`ifdef MIPS32_TRACE_TIMESTAMP_EN
        logic [15:0]       stamp;
`endif
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] result;
        logic [4:0]        ctrl;
    } entry_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PT   = (ADDR_W+1)'(POST_TRIG);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr, w_wr_nxt;
    logic [ADDR_W-1:0] r_rd_ptr, w_rd_nxt;
    logic [ADDR_W:0]   r_count, w_count_nxt;
    logic [ADDR_W:0]   r_post, w_post_nxt;
    logic              r_trig, w_trig_nxt;

    entry_t            r_mem [DEPTH];
    entry_t            r_hold;
    entry_t            w_wr_entry;
    entry_t            w_rd_entry;
    entry_t            w_rd_out;

    logic              w_wr_en;
    logic              w_pc_hit;
    logic              w_rd_valid;
    logic              w_pop;

`ifdef MIPS32_TRACE_TIMESTAMP_EN
    logic [15:0]       r_time;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_time <= '0;
        else        r_time <= r_time + 16'd1;
    end
`endif

    // Writes happen only while capturing; abort wins over a same-cycle write.
    assign w_wr_en    = (r_state == S_ARMED || r_state == S_POST) && bus.cap_valid && !abort;
    assign w_pc_hit   = bus.cap_valid && (bus.cap_pc == trig_pc);
    assign w_rd_valid = (r_state == S_DONE) && (r_count != '0);
    assign w_pop      = w_rd_valid && bus.rd_ready;

    always_comb begin
        w_wr_entry        = '0;
        w_wr_entry.pc     = bus.cap_pc;
        w_wr_entry.instr  = bus.cap_instr;
        w_wr_entry.result = bus.cap_result;
        w_wr_entry.ctrl   = bus.cap_ctrl;
`ifdef MIPS32_TRACE_TIMESTAMP_EN
        w_wr_entry.stamp  = r_time;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = r_wr_ptr;
        w_rd_nxt    = r_rd_ptr;
        w_count_nxt = r_count;
        w_post_nxt  = r_post;
        w_trig_nxt  = r_trig;

        // Ring write: once full, the oldest entry is overwritten so the read
        // pointer is dragged along with the write pointer.
        if (w_wr_en) begin
            w_wr_nxt = r_wr_ptr + 1'b1;
            if (r_count == FULL) w_rd_nxt    = r_rd_ptr + 1'b1;
            else                 w_count_nxt = r_count + 1'b1;
        end

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_wr_nxt    = '0;
            w_rd_nxt    = '0;
            w_count_nxt = '0;
            w_post_nxt  = '0;
            w_trig_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        w_state_nxt = S_ARMED;
                        w_wr_nxt    = '0;
                        w_rd_nxt    = '0;
                        w_count_nxt = '0;
                    end
                end
                S_ARMED: begin
                    // force_trig and a PC hit together are a single trigger.
                    if (force_trig || w_pc_hit) begin
                        w_trig_nxt  = 1'b1;
                        w_post_nxt  = PT;
                        w_state_nxt = (PT == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (bus.cap_valid) begin
                        w_post_nxt = r_post - ONE;
                        if (r_post == ONE) w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    // A trigger with nothing captured leaves nothing to drain.
                    if (r_count == '0) begin
                        w_state_nxt = S_IDLE;
                        w_trig_nxt  = 1'b0;
                    end else if (w_pop) begin
                        w_rd_nxt    = r_rd_ptr + 1'b1;
                        w_count_nxt = r_count - ONE;
                        if (r_count == ONE) begin
                            w_state_nxt = S_IDLE;
                            w_trig_nxt  = 1'b0;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_post   <= '0;
            r_trig   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            r_post   <= w_post_nxt;
            r_trig   <= w_trig_nxt;
        end
    end

    // Storage has no reset; only entries written since the last arm are read.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_entry;
    end

    assign w_rd_entry = r_mem[r_rd_ptr];

    // Holding copy keeps rd_* at their last presented value (zero from reset)
    // whenever the stream is idle, while the live path stays combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_hold <= '0;
        else if (w_rd_valid) r_hold <= w_rd_entry;
    end

    assign w_rd_out      = w_rd_valid ? w_rd_entry : r_hold;

    assign bus.rd_valid  = w_rd_valid;
    assign bus.rd_pc     = w_rd_out.pc;
    assign bus.rd_instr  = w_rd_out.instr;
    assign bus.rd_result = w_rd_out.result;
    assign bus.rd_ctrl   = w_rd_out.ctrl;
`ifdef MIPS32_TRACE_TIMESTAMP_EN
    assign bus.rd_time   = w_rd_out.stamp;
`endif

    assign state     = r_state;
    assign count     = r_count;
    assign triggered = r_trig;

endmodule

// File: tb/tb_mips32_trace_buffer.sv
module tb_mips32_trace_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PT    = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
        logic [4:0]  ctrl;
        logic [15:0] t;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0, abort = 1'b0, frc = 1'b0;
    logic [DW-1:0] trig_pc = '0;
    logic [1:0]    state;
    logic [AW:0]   count;
    logic          triggered;

    mips32_trace_buffer_if #(.DATA_W(DW)) tif();

    mips32_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .POST_TRIG(PT)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .force_trig(frc),
        .trig_pc(trig_pc), .bus(tif), .state(state), .count(count), .triggered(triggered)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: captured window as a queue, state as plain integers.
    ent_t        m_buf[$];
    ent_t        exp_q[$];
    int          m_state = 0;   // 0 idle, 1 armed, 2 post, 3 done
    int          m_post  = 0;
    bit          m_trig  = 0;
    logic [15:0] m_time  = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    function automatic void go_idle();
        m_state = 0; m_trig = 0; m_post = 0;
        m_buf.delete(); exp_q.delete();
    endfunction

    function automatic void push(input ent_t e);
        m_buf.push_back(e);
        if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
    endfunction

    function automatic void freeze();
        m_state = 3;
        foreach (m_buf[i]) exp_q.push_back(m_buf[i]);
    endfunction

    function automatic void model_step();
        ent_t e;
        bit   hit;
        e.pc = tif.cap_pc; e.instr = tif.cap_instr; e.result = tif.cap_result;
        e.ctrl = tif.cap_ctrl; e.t = m_time;
        hit = tif.cap_valid && (tif.cap_pc == trig_pc);
        if (abort) go_idle();
        else case (m_state)
            0: if (arm) begin m_buf.delete(); m_state = 1; end
            1: begin
                if (tif.cap_valid) push(e);
                if (frc || hit) begin
                    m_trig = 1; m_post = PT;
                    if (PT == 0) freeze(); else m_state = 2;
                end
            end
            2: if (tif.cap_valid) begin
                push(e); m_post--;
                if (m_post == 0) freeze();
            end
            default: begin
                if (m_buf.size() == 0) go_idle();
                else if (tif.rd_ready) begin
                    void'(m_buf.pop_front());
                    if (m_buf.size() == 0) go_idle();
                end
            end
        endcase
        m_time = m_time + 16'd1;
    endfunction

    // One clock: check visible state at the falling edge, advance the model
    // with this cycle's inputs, return just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        chk("state", {30'd0, state}, m_state);
        chk("count", {27'd0, count}, m_buf.size());
        chk("triggered", {31'd0, triggered}, {31'd0, m_trig});
        chk("rd_valid", {31'd0, tif.rd_valid}, {31'd0, (m_state == 3 && m_buf.size() != 0)});
        #2;
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Readout monitor: compares the presented entry with the scoreboard head,
    // popping on each accepted handshake.
    always @(negedge clk) begin
        if (rst_n && tif.rd_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rd_unexpected: got pc %0h expected no entry at %0t", tif.rd_pc, $time);
            end else begin
                chk("rd_pc", tif.rd_pc, exp_q[0].pc);
                chk("rd_instr", tif.rd_instr, exp_q[0].instr);
                chk("rd_result", tif.rd_result, exp_q[0].result);
                chk("rd_ctrl", {27'd0, tif.rd_ctrl}, {27'd0, exp_q[0].ctrl});
`ifdef MIPS32_TRACE_TIMESTAMP_EN
                chk("rd_time", {16'd0, tif.rd_time}, {16'd0, exp_q[0].t});
`endif
                if (tif.rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic retire(input logic [31:0] pc);
        tif.cap_valid = 1'b1; tif.cap_pc = pc;
        tif.cap_instr = $urandom; tif.cap_result = $urandom; tif.cap_ctrl = 5'($urandom);
        cycle();
        tif.cap_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1; cycle(); arm = 1'b0;
    endtask

    // Drain with rd_ready toggling 1,0,0,1 when bp is set; bounded by budget.
    task automatic drain(input bit bp);
        int k = 0;
        while (state != 2'b00 && k < 200) begin
            tif.rd_ready = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            cycle();
            k++;
        end
        tif.rd_ready = 1'b0;
        chk("drain_idle", {30'd0, state}, 32'd0);
    endtask

    task automatic model_reset();
        go_idle();
        m_time = '0;
    endtask

    initial begin
        tif.cap_valid = 1'b0; tif.cap_pc = '0; tif.cap_instr = '0;
        tif.cap_result = '0; tif.cap_ctrl = '0; tif.rd_ready = 1'b0;
        #3;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_trig", {31'd0, triggered}, 32'd0);
        chk("rst_rd_valid", {31'd0, tif.rd_valid}, 32'd0);
        chk("rst_rd_pc", tif.rd_pc, 32'd0);
        chk("rst_rd_ctrl", {27'd0, tif.rd_ctrl}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();

        // Basic window: trigger at 0x08, two post entries.
        trig_pc = 32'h08;
        do_arm();
        for (int i = 0; i < 5; i++) retire(32'(4 * i));
        chk("t1_state_done", {30'd0, state}, 32'd3);
        chk("t1_count", {27'd0, count}, 32'd5);
        chk("t1_first_pc", tif.rd_pc, 32'h00);
        drain(1'b0);

        // Overflow: 40 retirements, trigger at i=35; window is i=22..37.
        trig_pc = 32'(4 * 35);
        do_arm();
        for (int i = 0; i < 40; i++) retire(32'(4 * i));
        chk("ovf_count", {27'd0, count}, 32'd16);
        chk("ovf_first_pc", tif.rd_pc, 32'(4 * 22));
        drain(1'b1);

        // Forced trigger with no capture, then exactly PT post entries.
        trig_pc = 32'hFFFF_FFF0;
        do_arm();
        frc = 1'b1; cycle(); frc = 1'b0;
        chk("frc_trig", {31'd0, triggered}, 32'd1);
        chk("frc_state_post", {30'd0, state}, 32'd2);
        retire(32'h40);
        chk("frc_trig_hold", {31'd0, triggered}, 32'd1);
        retire(32'h44);
        chk("frc_state_done", {30'd0, state}, 32'd3);
        chk("frc_count", {27'd0, count}, 32'(PT));
        drain(1'b1);

        // Abort during POST with seven entries held.
        do_arm();
        for (int i = 0; i < 6; i++) retire(32'h100 + 32'(4 * i));
        frc = 1'b1; retire(32'h200); frc = 1'b0;
        chk("abt_count7", {27'd0, count}, 32'd7);
        abort = 1'b1; cycle(); abort = 1'b0;
        chk("abt_state", {30'd0, state}, 32'd0);
        chk("abt_count", {27'd0, count}, 32'd0);
        chk("abt_trig", {31'd0, triggered}, 32'd0);
        chk("abt_rd_valid", {31'd0, tif.rd_valid}, 32'd0);
        do_arm();
        retire(32'h300);
        chk("abt_rearm_count", {27'd0, count}, 32'd1);
        abort = 1'b1; cycle(); abort = 1'b0;

        // Randomized traffic checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            arm          = ($urandom % 6) == 0;
            abort        = ($urandom % 120) == 0;
            frc          = ($urandom % 40) == 0;
            tif.rd_ready = ($urandom % 3) != 0;
            if (($urandom % 20) == 0) trig_pc = 32'(4 * ($urandom % 32));
            tif.cap_valid  = $urandom % 2;
            tif.cap_pc     = 32'(4 * ($urandom % 32));
            tif.cap_instr  = $urandom;
            tif.cap_result = $urandom;
            tif.cap_ctrl   = 5'($urandom);
            cycle();
        end
        arm = 1'b0; abort = 1'b0; frc = 1'b0; tif.cap_valid = 1'b0; tif.rd_ready = 1'b0;

        // Asynchronous reset in the middle of a capture.
        trig_pc = 32'hFFFF_FFF0;
        do_arm();
        retire(32'h500);
        retire(32'h504);
        rst_n = 1'b0;
        #1;
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_count", {27'd0, count}, 32'd0);
        chk("arst_rd_pc", tif.rd_pc, 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        do_arm();
        retire(32'h600);
        chk("arst_rearm_count", {27'd0, count}, 32'd1);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mips32_trace_buffer.md
Name: mips32_trace_buffer

Overview:
- Synthesizable instruction-trace capture unit for the mips32 core; the on-chip successor to the printf-style per-instruction trace monitor.
- Each retired instruction presents PC, instruction word, ALU result and control bits (ALU select, branch, jump); entries are written into a circular buffer.
- A PC-match or forced trigger freezes the buffer after a programmable number of post-trigger entries.
- The frozen window drains oldest-first over a valid/ready stream to a debug port or bench.

Parameters:
- DATA_W, 32, width of the PC, instruction and result fields.
- DEPTH, 16, number of buffer entries; must be a power of two, minimum 4.
- ADDR_W, 4, log2(DEPTH).
- POST_TRIG, 8, entries recorded after the trigger entry; must satisfy POST_TRIG < DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  single-cycle pulse; starts capture from IDLE.
- abort  in  1  returns to IDLE from any state; buffer contents discarded.
- force_trig  in  1  immediate trigger while ARMED.
- trig_pc  in  DATA_W  PC value that fires the trigger.
- cap_valid  in  1  one retired instruction this cycle.
- cap_pc  in  DATA_W  PC of the retired instruction.
- cap_instr  in  DATA_W  instruction word.
- cap_result  in  DATA_W  ALU result.
- cap_ctrl  in  5  {alu_sel[2:0], branch, jump}.
- rd_valid  out  1  readout entry available.
- rd_ready  in  1  consumer accepts the entry.
- rd_pc  out  DATA_W  readout field.
- rd_instr  out  DATA_W  readout field.
- rd_result  out  DATA_W  readout field.
- rd_ctrl  out  5  readout field.
- state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE.
- count  out  ADDR_W+1  valid entries held; saturates at DEPTH.
- triggered  out  1  high from the trigger cycle until return to IDLE.

Behaviour:
- Reset: state IDLE; count 0; write pointer 0; read pointer 0; triggered 0; rd_valid 0; all rd_* data outputs 0; post counter 0.
- IDLE:
  - arm=1 → ARMED next cycle; count and pointers cleared.
  - cap_valid ignored.
- ARMED:
  - Each cap_valid writes one entry at wr_ptr; wr_ptr increments modulo DEPTH.
  - count increments and saturates at DEPTH.
  - Once full, the oldest entry is overwritten and the read pointer advances with the write pointer.
- Trigger fires in ARMED when force_trig=1, or when cap_valid=1 and cap_pc==trig_pc.
  - On a PC match, the matching entry is written in the same cycle.
  - Next state is POST; triggered=1; post counter loaded with POST_TRIG.
- Trigger priority: force_trig and a PC match in the same cycle count as one trigger. If cap_valid is also high, the entry is written.
- POST:
  - Each cap_valid writes as in ARMED and decrements the post counter.
  - When the counter reaches 0 → DONE; the decrement to 0 is the last write.
  - POST_TRIG=0 → DONE directly from the trigger cycle.
- DONE:
  - Writes ignored.
  - rd_valid = (count != 0).
  - rd_* driven combinationally from the entry at the read pointer, oldest first.
  - rd_valid && rd_ready pops: read pointer +1 mod DEPTH, count −1.
  - Pop of the last entry → IDLE next cycle; triggered cleared.
  - rd_valid must not drop without a pop while count != 0.
- abort: highest priority in all states → IDLE next cycle. count 0; triggered 0; rd_valid 0 in the following cycle.
- arm outside IDLE: ignored.
- Asynchronous reset mid-capture or mid-readout: immediate return to reset values. Buffer RAM contents need not be cleared.
- Data outputs while rd_valid=0 hold their last value; they are don't-care to the consumer.

Optional Feature:
- Macro: MIPS32_TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a 16-bit free-running cycle counter, reset to 0, wrapping at 0xFFFF.
  - The counter value is stored with every written entry.
  - Adds output port rd_time (16 bits), presented alongside the other rd_* fields.
- Undefined: no counter, no rd_time port, no timestamp storage; all other behaviour identical.

Test Plan:
- Reset, then arm; retire 5 instructions with PC 0x00,0x04,…,0x10, trig_pc=0x08, POST_TRIG=2. → DONE after the PC 0x10 write; count=5; drain yields PCs 0x00..0x10 in order; IDLE after the 5th pop.
- Overflow: DEPTH=16, 40 retirements with PC=4*i, trigger at i=35, POST_TRIG=2. → DONE after i=37; count=16; drain yields i=22..37.
- force_trig in ARMED with cap_valid=0, then 8 retirements. → exactly POST_TRIG=8 entries after the trigger; triggered=1 throughout; DONE after the 8th.
- Readout backpressure: toggle rd_ready 1,0,0,1 in DONE. → rd_valid stays 1; rd_* stable while rd_ready=0; exactly one pop per accepted handshake.
- abort during POST with count=7. → IDLE next cycle; count=0; triggered=0; rd_valid=0; a subsequent arm restarts from an empty buffer.
- With MIPS32_TRACE_TIMESTAMP_EN: retirements on cycles 3, 4 and 9 after reset. → drained rd_time values are 3, 4, 9.
